// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if
//   Bundles the three requester channels (fetch, data read, data write), the
//   single-port memory hookup and the sticky address-error flag of
//   unified_mem_arbiter.
//   modport slave  : the arbiter side (takes requests, drives grants/memory)
//   modport master : the core + memory side (drives requests, memory data)
interface unified_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        dr_req;
  logic [31:0] dr_addr;
  logic        dr_gnt;
  logic        dr_rvalid;
  logic [31:0] dr_rdata;

  logic        dw_req;
  logic [31:0] dw_addr;
  logic [31:0] dw_data;
  logic [3:0]  dw_byte;
  logic        dw_gnt;

  logic        mem_read_ready;
  logic [29:0] mem_read_address;
  logic [31:0] mem_read_data;
  logic        mem_write_ready;
  logic [29:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_byte;

  logic        addr_err;

  modport slave (
    input  if_req, if_addr, dr_req, dr_addr,
    input  dw_req, dw_addr, dw_data, dw_byte,
    input  mem_read_data,
    output if_gnt, if_rvalid, if_rdata,
    output dr_gnt, dr_rvalid, dr_rdata,
    output dw_gnt,
    output mem_read_ready, mem_read_address,
    output mem_write_ready, mem_write_address, mem_write_data, mem_write_byte,
    output addr_err
  );

  modport master (
    output if_req, if_addr, dr_req, dr_addr,
    output dw_req, dw_addr, dw_data, dw_byte,
    output mem_read_data,
    input  if_gnt, if_rvalid, if_rdata,
    input  dr_gnt, dr_rvalid, dr_rdata,
    input  dw_gnt,
    input  mem_read_ready, mem_read_address,
    input  mem_write_ready, mem_write_address, mem_write_data, mem_write_byte,
    input  addr_err
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-access-per-cycle memory between instruction fetch,
//   data read and data write. Grants are combinational in the request cycle;
//   read data returns to the owning requester one cycle later with an rvalid
//   strobe, and each rdata output holds its last returned value.
//   Priority dw > dr > if, with fetch forced through after STARVE_LIMIT
//   consecutive denied cycles.
//   Build option: define UNIFIED_MEM_ARBITER_RR_EN to replace the starvation
//   counter with dr/if round-robin on ties (dw keeps absolute priority).
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-low reset
//   bus    : unified_mem_arbiter_if.slave (requesters, memory port, addr_err)
//
// Read-owner FSM:
//   state     | meaning
//   OWN_NONE  | no read in flight, no rvalid this cycle
//   OWN_IF    | fetch read issued last cycle, return data to fetch
//   OWN_DR    | data read issued last cycle, return data to data read
module unified_mem_arbiter #(
  parameter int MEMSIZE      = 131072,
  parameter int STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  reset,
  unified_mem_arbiter_if.slave bus
);

  localparam int ADDR_BITS = $clog2(MEMSIZE);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DR} owner_t;

  owner_t      owner_q, owner_d;
  logic        if_gnt, dr_gnt, dw_gnt, rd_gnt;
  logic [31:0] gaddr;
  logic [31:0] if_rdata_q, dr_rdata_q;
  logic        addr_err_q;
  logic        unused_addr_lsbs;

  // Grants are forced low while reset is asserted.
`ifdef UNIFIED_MEM_ARBITER_RR_EN
  logic last_if_q;  // 1: fetch won the most recent dr/if tie
  logic tie;

  assign tie = bus.if_req && bus.dr_req && !bus.dw_req;

  always_comb begin
    dw_gnt = reset && bus.dw_req;
    dr_gnt = 1'b0;
    if_gnt = 1'b0;
    if (reset && !bus.dw_req) begin
      if (tie) begin
        dr_gnt = last_if_q;
        if_gnt = !last_if_q;
      end else begin
        dr_gnt = bus.dr_req;
        if_gnt = bus.if_req;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   last_if_q <= 1'b1;
    else if (tie) last_if_q <= if_gnt;
  end
`else
  logic [3:0] starve_cnt;
  logic       force_if;

  assign force_if = bus.if_req && (starve_cnt == 4'(STARVE_LIMIT));

  always_comb begin
    dw_gnt = reset && bus.dw_req && !force_if;
    dr_gnt = reset && bus.dr_req && !bus.dw_req && !force_if;
    if_gnt = reset && bus.if_req && (force_if || (!bus.dw_req && !bus.dr_req));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      starve_cnt <= 4'd0;
    else if (!bus.if_req || if_gnt)
      starve_cnt <= 4'd0;
    else if (starve_cnt != 4'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + 4'd1;
  end
`endif

  assign rd_gnt = if_gnt || dr_gnt;

  always_comb begin
    gaddr = 32'd0;
    if (if_gnt)      gaddr = bus.if_addr;
    else if (dr_gnt) gaddr = bus.dr_addr;
    else if (dw_gnt) gaddr = bus.dw_addr;
  end

  // Byte offset is irrelevant to a word-wide memory.
  assign unused_addr_lsbs = ^gaddr[1:0];

  assign bus.if_gnt            = if_gnt;
  assign bus.dr_gnt            = dr_gnt;
  assign bus.dw_gnt            = dw_gnt;
  assign bus.mem_read_ready    = rd_gnt;
  assign bus.mem_read_address  = rd_gnt ? gaddr[31:2] : 30'd0;
  assign bus.mem_write_ready   = dw_gnt;
  assign bus.mem_write_address = dw_gnt ? gaddr[31:2] : 30'd0;
  assign bus.mem_write_data    = dw_gnt ? bus.dw_data : 32'd0;
  assign bus.mem_write_byte    = dw_gnt ? bus.dw_byte : 4'd0;

  // Out-of-range flag is sticky; the access itself is still issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      addr_err_q <= 1'b0;
    else if ((gaddr >> ADDR_BITS) != 32'd0)
      addr_err_q <= 1'b1;
  end

  assign bus.addr_err = addr_err_q;

  // Owner FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) owner_q <= OWN_NONE;
    else        owner_q <= owner_d;
  end

  // Owner FSM: next state -- only the most recent read grant matters
  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt)      owner_d = OWN_IF;
    else if (dr_gnt) owner_d = OWN_DR;
  end

  // Owner FSM: outputs. Returning data passes straight through; the hold
  // registers keep it visible afterwards.
  always_comb begin
    bus.if_rvalid = (owner_q == OWN_IF);
    bus.dr_rvalid = (owner_q == OWN_DR);
    bus.if_rdata  = (owner_q == OWN_IF) ? bus.mem_read_data : if_rdata_q;
    bus.dr_rdata  = (owner_q == OWN_DR) ? bus.mem_read_data : dr_rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rdata_q <= 32'd0;
      dr_rdata_q <= 32'd0;
    end else begin
      if (owner_q == OWN_IF) if_rdata_q <= bus.mem_read_data;
      if (owner_q == OWN_DR) dr_rdata_q <= bus.mem_read_data;
    end
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-access-per-cycle memory between the pipeline's three requesters: instruction fetch, data read and data write.
- Grants at most one access per cycle, drives the memory port, and returns read data to the owner one cycle later with a valid strobe.
- Uses fixed priority with a fetch anti-starvation counter.
- Sits between the pipeline core and the unified `memory` instance, replacing the separate imem/dmem hookup.

Parameters:
- MEMSIZE, 131072, memory size in bytes; sets the address range check.
- STARVE_LIMIT, 4, number of consecutive denied fetch cycles before fetch is forced to win; legal range 1..15.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- if_req  input  1  fetch read request
- if_addr  input  32  fetch byte address
- if_gnt  output  1  fetch accepted this cycle
- if_rvalid  output  1  fetch data valid
- if_rdata  output  32  fetch read data
- dr_req  input  1  data read request
- dr_addr  input  32  data read byte address
- dr_gnt  output  1  data read accepted this cycle
- dr_rvalid  output  1  data read data valid
- dr_rdata  output  32  data read data
- dw_req  input  1  data write request
- dw_addr  input  32  data write byte address
- dw_data  input  32  write data
- dw_byte  input  4  byte-enable mask
- dw_gnt  output  1  write accepted this cycle
- mem_read_ready  output  1  memory read strobe
- mem_read_address  output  30  word address
- mem_read_data  input  32  memory read data, valid one cycle after the strobe
- mem_write_ready  output  1  memory write strobe
- mem_write_address  output  30  word address
- mem_write_data  output  32  write data to memory
- mem_write_byte  output  4  byte enables to memory
- addr_err  output  1  sticky out-of-range flag

Behaviour:
- Reset (reset=0, async):
  - all gnt and rvalid outputs 0; mem_read_ready=0, mem_write_ready=0
  - starve_cnt=0; owner tag=NONE; addr_err=0
  - rdata outputs and mem address/data outputs 0
- Grant is combinational in the request cycle. Exactly one of if_gnt/dr_gnt/dw_gnt is high, or none.
- Priority: dw > dr > if. Exception: when starve_cnt == STARVE_LIMIT and if_req=1, fetch wins over both data requesters.
- starve_cnt:
  - increments (saturating at STARVE_LIMIT) each cycle in which if_req=1 and if_gnt=0
  - cleared when if_gnt=1 or if_req=0
- Memory drive:
  - Read grant: mem_read_ready=1, mem_read_address = granted addr[31:2].
  - Write grant: mem_write_ready=1, mem_write_address=dw_addr[31:2], mem_write_data=dw_data, mem_write_byte=dw_byte.
  - The two strobes are never high in the same cycle. Address bits [1:0] are ignored.
- Read return:
  - The owner tag (NONE/IF/DR) is registered on each read grant.
  - In cycle N+1 the tagged requester's rvalid=1 for exactly one cycle, and its rdata = mem_read_data.
  - Otherwise rdata holds the last returned value.
- Back-to-back reads are allowed every cycle; one read is in flight at any time.
- A write granted in cycle N followed by a read of the same word in cycle N+1 returns the new data. The memory is write-first, so the arbiter adds no bypass.
- Reset asserted with a read in flight: tag cleared, and no rvalid is produced after reset releases.
- Out-of-range: a granted address with addr[31:$clog2(MEMSIZE)] != 0 sets addr_err, which stays set until reset. The access is still issued.
- A request held with no grant must stay stable. The arbiter keeps no queue; an ungranted requester retries the next cycle.
- A write with dw_byte=4'h0 is still granted and strobed, with no memory change.

Optional Feature:
- Macro UNIFIED_MEM_ARBITER_RR_EN.
- Defined: dr and if alternate round-robin whenever both request in the same cycle.
  - A 1-bit last-winner register resets to IF, so dr wins the first tie.
  - dw still has absolute priority.
  - starve_cnt logic is removed and STARVE_LIMIT is unused.
- Undefined: fixed priority with the starvation counter, as described under Behaviour.

Test Plan:
- if_req=1, if_addr=0x100 alone → if_gnt=1 and mem_read_address=0x40 same cycle; next cycle if_rvalid=1 and if_rdata equals the memory word at 0x100.
- if_req, dr_req, dw_req all =1, dw_addr=0x2000, dw_data=0xDEADBEEF, dw_byte=4'hF → dw_gnt only; mem_write_ready=1, mem_read_ready=0. Next cycle dr_gnt=1 (dw_req dropped).
- dr_req and if_req held high continuously, STARVE_LIMIT=4 → dr_gnt for 4 cycles, if_gnt on the 5th, then dr_gnt resumes with starve_cnt=0. With RR_EN: alternating dr, if, dr, if.
- Write 0x12345678 to 0x300 in cycle N, dr read of 0x300 in cycle N+1 → dr_rvalid in N+2 with dr_rdata=0x12345678.
- Read granted, then reset pulled low for one cycle before data returns → no rvalid after release; all outputs 0 during reset.
- if_addr=0x00020000 with MEMSIZE=131072 → addr_err=1 and remains 1 after later in-range accesses, until reset.
